// File: rtl/hash_uart_reporter.sv
// hash_uart_reporter
//
// Buffers 128-bit hashes from the validator in a small FIFO. Each hash goes out
// on the uart_wrapper byte stream as one ASCII line: 32 lowercase hex digits,
// MSB nibble first, then CR LF.
//
// Optional build macro HASH_REPORT_SEQ_EN: each line is prefixed with an 8-bit
// frame sequence number as 2 hex digits and a space (37-byte frames). The
// number wraps from ff to 00.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   hash_i       hash value from the validator
//   hash_valid_i single-cycle strobe qualifying hash_i; it has no back-pressure
//   tx_data      registered ASCII byte to the UART
//   tx_valid     registered byte-valid flag
//   tx_ready     UART accepts the byte this cycle
//   fifo_level   current FIFO occupancy
//   drop_cnt     saturating count of hashes lost because the FIFO was full
module hash_uart_reporter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [127:0]               hash_i,
    input  logic                       hash_valid_i,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

`ifdef HASH_REPORT_SEQ_EN
    typedef enum logic [2:0] {
        StIdle, StLoad, StSeqHi, StSeqLo, StSp, StHex, StCr, StLf
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLoad, StHex, StCr, StLf
    } state_e;
`endif

    // FIFO
    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [DROP_W-1:0] drop_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [127:0]  head;

    // Frame serializer
    state_e        state_q;
    logic [127:0]  sh_q;
    logic [4:0]    nib_cnt_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
`ifdef HASH_REPORT_SEQ_EN
    logic [7:0]    seq_q;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    // Full is judged on pre-pop occupancy, so a push in the LOAD cycle of a
    // full FIFO is still dropped.
    assign push  = hash_valid_i && !full;
    assign pop   = (state_q == StLoad) && !empty;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hash_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (!push && pop) begin
                level_q <= level_q - 1'b1;
            end
            if (hash_valid_i && full && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // tx_data is loaded one state ahead so the byte is already registered
    // when tx_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            nib_cnt_q  <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
`ifdef HASH_REPORT_SEQ_EN
            seq_q      <= 8'h00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_valid_q <= 1'b0;
                    if (!empty) state_q <= StLoad;
                end
                StLoad: begin
                    sh_q       <= head;
                    nib_cnt_q  <= '0;
                    tx_valid_q <= 1'b1;
`ifdef HASH_REPORT_SEQ_EN
                    tx_data_q  <= hex_ascii(seq_q[7:4]);
                    state_q    <= StSeqHi;
`else
                    tx_data_q  <= hex_ascii(head[127:124]);
                    state_q    <= StHex;
`endif
                end
`ifdef HASH_REPORT_SEQ_EN
                StSeqHi: begin
                    if (tx_ready) begin
                        tx_data_q <= hex_ascii(seq_q[3:0]);
                        state_q   <= StSeqLo;
                    end
                end
                StSeqLo: begin
                    if (tx_ready) begin
                        tx_data_q <= 8'h20;
                        state_q   <= StSp;
                    end
                end
                StSp: begin
                    if (tx_ready) begin
                        tx_data_q <= hex_ascii(sh_q[127:124]);
                        state_q   <= StHex;
                    end
                end
`endif
                StHex: begin
                    if (tx_ready) begin
                        sh_q      <= {sh_q[123:0], 4'h0};
                        nib_cnt_q <= nib_cnt_q + 1'b1;
                        if (nib_cnt_q == 5'd31) begin
                            tx_data_q <= 8'h0D;
                            state_q   <= StCr;
                        end else begin
                            tx_data_q <= hex_ascii(sh_q[123:120]);
                        end
                    end
                end
                StCr: begin
                    if (tx_ready) begin
                        tx_data_q <= 8'h0A;
                        state_q   <= StLf;
                    end
                end
                StLf: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= empty ? StIdle : StLoad;
`ifdef HASH_REPORT_SEQ_EN
                        seq_q      <= seq_q + 8'h01;
`endif
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_hash_uart_reporter.sv
// Testbench for hash_uart_reporter (DEPTH=4, DROP_W=16). Expected lines are
// built from the hash with string formatting; FIFO drop decisions come from a
// small occupancy count stepped by the documented strobe-to-LOAD latency.
module tb_hash_uart_reporter;

`ifdef HASH_REPORT_SEQ_EN
    localparam int FRAME = 37;
`else
    localparam int FRAME = 34;
`endif

    typedef logic [295:0] vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] hash_i = '0;
    logic         hash_valid_i = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [2:0]   fifo_level;
    logic [15:0]  drop_cnt;

    hash_uart_reporter #(
        .DEPTH (4),
        .DROP_W(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hash_i      (hash_i),
        .hash_valid_i(hash_valid_i),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int stab_err = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_seq = 8'h00;
    int model_level;
    int model_drop = 0;

    // Byte monitor: records each handshake and checks hold-while-stalled.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic check(input string tag, input vec_t obs, input vec_t expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void add_frame(input logic [127:0] h);
        string s;
        s = $sformatf("%h", h);
`ifdef HASH_REPORT_SEQ_EN
        s = {$sformatf("%h ", exp_seq), s};
        exp_seq = exp_seq + 8'h01;
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic logic [127:0] rnd_hash();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the strobe edge.
    task automatic strobe(input logic [127:0] h);
        hash_i = h;
        hash_valid_i = 1'b1;
        @(posedge clk);
        #1;
        hash_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hash_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        exp_seq = 8'h00;
        model_drop = 0;
    endtask

    task automatic drain(input string tag, input bit rnd);
        vec_t gv, ev;
        int n;
        for (int c = 0; c < 20000; c++) begin
            if (got.size() >= exp_q.size()) break;
            @(posedge clk);
            #1;
            tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_idle"}, vec_t'(tx_valid), vec_t'(0));
        check({tag, "_count"}, vec_t'(got.size()), vec_t'(exp_q.size()));
        check({tag, "_stable"}, vec_t'(stab_err), vec_t'(0));
        n = exp_q.size() / FRAME;
        for (int f = 0; f < n; f++) begin
            gv = '0;
            ev = '0;
            for (int i = 0; i < FRAME; i++) begin
                ev = {ev[287:0], exp_q.pop_front()};
                gv = {gv[287:0], (got.size() > 0) ? got.pop_front() : 8'hxx};
            end
            check($sformatf("%s_frame%0d", tag, f), gv, ev);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [127:0] hs;
        int lat;
        int k;

        // Reset state
        #2;
        check("rst_valid", vec_t'(tx_valid), vec_t'(0));
        check("rst_data", vec_t'(tx_data), vec_t'(8'h00));
        check("rst_level", vec_t'(fifo_level), vec_t'(0));
        check("rst_drop", vec_t'(drop_cnt), vec_t'(0));
        @(posedge clk);
        #1;
        do_reset();

        // 1: known hash, ready high, latency 2
        tx_ready = 1'b1;
        hs = 128'h0123456789abcdeffedcba9876543210;
        strobe(hs);
        add_frame(hs);
        lat = 0;
        while (!tx_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", vec_t'(lat), vec_t'(2));
        drain("t1", 1'b0);

        // 2: all-ones, random ready
        strobe('1);
        add_frame('1);
        drain("t2", 1'b1);

        // Random hashes in small bursts, random ready
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                hs = rnd_hash();
                strobe(hs);
                add_frame(hs);
            end
            drain($sformatf("rnd%0d", r), 1'b1);
        end

        // 3: overflow with ready low; first pop lands two edges after strobe 0
        tx_ready = 1'b0;
        model_level = 0;
        for (int s = 0; s < 6; s++) begin
            hs = rnd_hash();
            hash_i = hs;
            hash_valid_i = 1'b1;
            @(posedge clk);
            #1;
            if (model_level < 4) begin
                model_level++;
                add_frame(hs);
            end else begin
                model_drop++;
            end
            if (s == 2) model_level--;
            if (s >= 4) begin
                check($sformatf("t3_level_s%0d", s), vec_t'(fifo_level), vec_t'(model_level));
            end
        end
        hash_valid_i = 1'b0;
        check("t3_drop", vec_t'(drop_cnt), vec_t'(model_drop));

        // 4: strobe into a full FIFO on the LOAD-pop edge after the first LF
        tx_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h0A) break;
        end
        @(posedge clk);
        #1;
        strobe(rnd_hash());
        model_drop++;
        model_level--;
        check("t4_level", vec_t'(fifo_level), vec_t'(model_level));
        check("t4_drop", vec_t'(drop_cnt), vec_t'(model_drop));
        drain("t34", 1'b0);

        // 5: reset in the middle of the hex digits
        strobe(rnd_hash());
        for (int c = 0; c < 100; c++) begin
            if (got.size() >= 10) break;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("t5_valid", vec_t'(tx_valid), vec_t'(0));
        check("t5_level", vec_t'(fifo_level), vec_t'(0));
        check("t5_drop", vec_t'(drop_cnt), vec_t'(0));
        @(posedge clk);
        #1;
        do_reset();
        hs = rnd_hash();
        strobe(hs);
        add_frame(hs);
        drain("t5", 1'b0);

`ifdef HASH_REPORT_SEQ_EN
        // 6: sequence prefix and wrap
        @(posedge clk);
        #1;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            hs = rnd_hash();
            strobe(hs);
            add_frame(hs);
        end
        drain("t6", 1'b0);
        while (exp_seq != 8'hff) begin
            k = (8'hff - exp_seq) < 3 ? int'(8'hff - exp_seq) : 3;
            for (int j = 0; j < k; j++) begin
                hs = rnd_hash();
                strobe(hs);
                add_frame(hs);
            end
            drain("t6_run", 1'b0);
        end
        for (int j = 0; j < 2; j++) begin
            hs = rnd_hash();
            strobe(hs);
            add_frame(hs);
        end
        drain("t6_wrap", 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
